// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM pipeline stage:
//   - mem_op_e    : memory operation codes carried in EX/MEM
//   - rmw_state_e : sub-word store read-modify-write sequencer states
//   - helpers     : load/store classification and alignment check
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } rmw_state_e;

  function automatic logic is_load(mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfword ops need an even address, word ops a multiple of four.
  // Byte ops can never be misaligned.
  function automatic logic is_misaligned(mem_op_e op, logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_SW:          return |lo;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Bundles the EX/MEM inputs, the data_memory bus and the MEM/WB outputs of the
// MEM stage.
//   slave  : the MEM stage view (consumes EX/MEM + rdata, drives memory + WB)
//   master : the surrounding pipeline / memory view
// -----------------------------------------------------------------------------
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);
  // EX/MEM side
  logic              in_valid;
  logic [3:0]        in_mem_op;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_wdata;
  logic [4:0]        in_rd;
  logic              in_reg_write;
  logic              flush;
  logic              stall;
  // data_memory side
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] rdata;
  // MEM/WB side
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_rd;
  logic              wb_reg_write;
  logic              wb_misalign;

  modport slave (
    input  in_valid, in_mem_op, in_alu, in_wdata, in_rd, in_reg_write, flush, rdata,
    output stall, addr, wdata, MemWrite, MemRead,
    output wb_valid, wb_data, wb_rd, wb_reg_write, wb_misalign
  );

  modport master (
    output in_valid, in_mem_op, in_alu, in_wdata, in_rd, in_reg_write, flush, rdata,
    input  stall, addr, wdata, MemWrite, MemRead,
    input  wb_valid, wb_data, wb_rd, wb_reg_write, wb_misalign
  );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// -----------------------------------------------------------------------------
// mem_access_stage_load_align
// Combinational lane logic for a 32-bit little-endian memory word.
//   i_word   : word read from data_memory
//   i_off    : byte offset within the word (address bits [1:0])
//   i_op     : memory operation
//   i_store  : store data (lane source for SB/SH)
//   o_load   : selected byte/halfword, sign- or zero-extended (word for LW)
//   o_merged : i_word with the SB/SH target lane replaced by store data
// -----------------------------------------------------------------------------
module mem_access_stage_load_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_off,
  input  mem_op_e           i_op,
  input  logic [DATA_W-1:0] i_store,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_bit_off;

  assign w_bit_off = {i_off, 3'b000};
  assign w_half    = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    o_load = i_word;
    case (i_op)
      MEM_LB:  o_load = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_load = {24'h000000, w_byte};
      MEM_LH:  o_load = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_load = {16'h0000, w_half};
      default: o_load = i_word;
    endcase
  end

  // SH only ever reaches here with i_off[0]==0, so w_bit_off is 0 or 16.
  always_comb begin
    o_merged = i_word;
    case (i_op)
      MEM_SB:  o_merged[w_bit_off +: 8]  = i_store[7:0];
      MEM_SH:  o_merged[w_bit_off +: 16] = i_store[15:0];
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage between EX/MEM and data_memory, producing MEM/WB.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mem_access_stage_if.slave
//         EX/MEM in  : in_valid, in_mem_op, in_alu, in_wdata, in_rd,
//                      in_reg_write, flush
//         upstream   : stall (combinational)
//         data_memory: addr (word index), wdata, MemWrite, MemRead, rdata
//         MEM/WB out : wb_valid, wb_data, wb_rd, wb_reg_write, wb_misalign
// Word loads/stores finish in one cycle. SB/SH have no byte enables to use,
// so they read the word (stalling upstream), merge the lane, and write it back
// the following cycle.
// -----------------------------------------------------------------------------
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_stage_if.slave   bus
);

  mem_op_e           w_op;
  logic [IDX_W-1:0]  w_idx;
  logic              w_mis;
  logic              w_load;
  logic              w_store;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  logic              w_stall;
  logic              w_rd;
  logic              w_wr;
  logic [IDX_W-1:0]  w_addr_idx;
  logic [DATA_W-1:0] w_wdata;
  logic              w_accept;
  logic              w_start_rmw;

  rmw_state_e        r_state;
  logic [DATA_W-1:0] r_merged_p0;
  logic [IDX_W-1:0]  r_idx_p0;

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic [4:0]        r_rd_p1;
  logic              r_reg_write_p1;
  logic              r_misalign_p1;

  assign w_op    = mem_op_e'(bus.in_mem_op);
  assign w_idx   = bus.in_alu[IDX_W+1:2];
  assign w_mis   = is_misaligned(w_op, bus.in_alu[1:0]);
  assign w_load  = is_load(w_op);
  assign w_store = is_store(w_op);

  mem_access_stage_load_align u_align (
    .i_word   (bus.rdata),
    .i_off    (bus.in_alu[1:0]),
    .i_op     (w_op),
    .i_store  (bus.in_wdata),
    .o_load   (w_load_data),
    .o_merged (w_merged)
  );

  // Memory strobes, stall and accept. Everything is held at 0 during reset,
  // which also aborts an in-flight RMW write.
  always_comb begin
    w_stall     = 1'b0;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_addr_idx  = '0;
    w_wdata     = '0;
    w_accept    = 1'b0;
    w_start_rmw = 1'b0;
    if (!rst) begin
      if (r_state == RMW_WR) begin
        // EX/MEM is still held by last cycle's stall; flush aborts the write.
        w_addr_idx = r_idx_p0;
        w_wdata    = r_merged_p0;
        w_wr       = ~bus.flush;
        w_accept   = bus.in_valid & ~bus.flush;
      end else if (bus.in_valid && !bus.flush) begin
        if (w_mis) begin
          w_accept = 1'b1;
        end else begin
          case (w_op)
            MEM_SB, MEM_SH: begin
              w_rd        = 1'b1;
              w_stall     = 1'b1;
              w_start_rmw = 1'b1;
              w_addr_idx  = w_idx;
            end
            MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: begin
              w_rd       = 1'b1;
              w_addr_idx = w_idx;
              w_accept   = 1'b1;
            end
            MEM_SW: begin
              w_wr       = 1'b1;
              w_addr_idx = w_idx;
              w_wdata    = bus.in_wdata;
              w_accept   = 1'b1;
            end
            default: w_accept = 1'b1;
          endcase
        end
      end
    end
  end

  // Stage p0: RMW sequencer and merged-word capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_start_rmw) r_state <= RMW_WR;
        RMW_WR:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_start_rmw) begin
      r_merged_p0 <= w_merged;
      r_idx_p0    <= w_idx;
    end
  end

  // Stage p1: MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1       <= 1'b0;
      r_reg_write_p1 <= 1'b0;
      r_data_p1      <= '0;
      r_rd_p1        <= '0;
      r_misalign_p1  <= 1'b0;
    end else begin
      r_vld_p1       <= w_accept;
      r_reg_write_p1 <= w_accept & bus.in_reg_write & ~w_mis & ~w_store;
      if (w_accept) begin
        r_rd_p1       <= bus.in_rd;
        r_misalign_p1 <= w_mis;
        r_data_p1     <= (w_load && !w_mis) ? w_load_data : bus.in_alu;
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.MemRead      = w_rd;
  assign bus.MemWrite     = w_wr;
  assign bus.addr         = {{(DATA_W-IDX_W){1'b0}}, w_addr_idx};
  assign bus.wdata        = w_wdata;
  assign bus.wb_valid     = r_vld_p1;
  assign bus.wb_data      = r_data_p1;
  assign bus.wb_rd        = r_rd_p1;
  assign bus.wb_reg_write = r_reg_write_p1;
  assign bus.wb_misalign  = r_misalign_p1;

endmodule
